// File: rtl/ov7725_sccb_wr_pkg.sv
// Shared constants for the OV7725 SCCB register writer: state codes, bit/byte
// phase sizes, the default device ID and the per-quarter pin decode.
package ov7725_sccb_wr_pkg;

    localparam logic [7:0] DEV_ID_OV7725 = 8'h42;

    localparam int QTRS_PER_BIT  = 4;
    localparam int BITS_PER_BYTE = 8;
    localparam logic [1:0] QTR_LAST = 2'(QTRS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(BITS_PER_BYTE - 1);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_START = 4'd1;
    localparam logic [3:0] ST_ID    = 4'd2;
    localparam logic [3:0] ST_ACK1  = 4'd3;
    localparam logic [3:0] ST_ADDR  = 4'd4;
    localparam logic [3:0] ST_ACK2  = 4'd5;
    localparam logic [3:0] ST_DATA  = 4'd6;
    localparam logic [3:0] ST_ACK3  = 4'd7;
    localparam logic [3:0] ST_STOP  = 4'd8;
    localparam logic [3:0] ST_DONE  = 4'd9;

    typedef struct packed {
        logic scl;
        logic sda;
        logic oe;
    } sccb_pins_t;

    localparam sccb_pins_t PINS_IDLE = '{scl: 1'b1, sda: 1'b1, oe: 1'b0};

    // Pin levels for one quarter of a bit; SDA only moves while SCL is low,
    // except the START fall (q1) and the STOP rise (q2).
    function automatic sccb_pins_t pins_for(input logic [3:0] st, input logic [1:0] q,
                                            input logic b);
        sccb_pins_t p;
        p = PINS_IDLE;
        case (st)
            ST_START: begin
                p.oe  = 1'b1;
                p.scl = (q <= 2'd1);
                p.sda = (q == 2'd0);
            end
            ST_ID, ST_ADDR, ST_DATA: begin
                p.oe  = 1'b1;
                p.sda = b;
                p.scl = (q == 2'd1) || (q == 2'd2);
            end
            ST_ACK1, ST_ACK2, ST_ACK3: begin
                p.oe  = 1'b0;
                p.sda = 1'b1;
                p.scl = (q == 2'd1) || (q == 2'd2);
            end
            ST_STOP: begin
                p.oe  = 1'b1;
                p.scl = (q != 2'd0);
                p.sda = (q >= 2'd2);
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ov7725_sccb_wr_qtr_tick.sv
// Quarter-bit tick generator: one-cycle tick every DIV enabled cycles,
// held at zero while disabled so each transfer starts on a fresh count.
module sccb_qtr_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [9:0] LAST = 10'(DIV - 1);

    logic [9:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 10'd1;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/ov7725_sccb_wr.sv
// SCCB 3-phase write master for the OV7725: sends DEV_ID, register address and
// register value, checks the don't-care ACK slots, and pulses cfg_end when done.
module ov7725_sccb_wr
    import ov7725_sccb_wr_pkg::*;
#(
    parameter logic [7:0] DEV_ID  = DEV_ID_OV7725,
    parameter int         QTR_DIV = 50
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [15:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        ack_err,
    output logic        sccb_scl,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic [3:0]  state_dbg
);

    // Handshake: cfg_start is taken only when idle (busy=0); busy then stays
    // high through the single cfg_end cycle, and a new start is legal right after.
    logic [3:0]  state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] data_q, data_d;
    logic        ack_err_q, ack_err_d;
    logic        end_q, busy_q;
    sccb_pins_t  pins_q;

    logic        accept, tick_en, tick, is_ack;
    logic [7:0]  byte_d;
    logic        bit_val_d;

    assign accept  = (state_q == ST_IDLE) && cfg_start;
    assign tick_en = accept || ((state_q != ST_IDLE) && (state_q != ST_DONE));
    assign is_ack  = state_q inside {ST_ACK1, ST_ACK2, ST_ACK3};

    sccb_qtr_tick #(.DIV(QTR_DIV)) u_qtr_tick (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_START;
                    qtr_d   = 2'd0;
                    bit_d   = 3'd0;
                    data_d  = cfg_data;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (is_ack && (qtr_q == 2'd2) && sda_i) begin
                        ack_err_d = 1'b1;
                    end
                    if (qtr_q == QTR_LAST) begin
                        case (state_q)
                            ST_START: state_d = ST_ID;
                            ST_ID, ST_ADDR, ST_DATA: begin
                                bit_d = bit_q + 3'd1;
                                if (bit_q == BIT_LAST) begin
                                    state_d = state_q + 4'd1;
                                end
                            end
                            ST_ACK1: state_d = ST_ADDR;
                            ST_ACK2: state_d = ST_DATA;
                            ST_ACK3: state_d = ST_STOP;
                            ST_STOP: state_d = ST_DONE;
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pins are decoded from the next state so the registered outputs line up
    // with the state they belong to.
    always_comb begin
        case (state_d)
            ST_ID:   byte_d = DEV_ID;
            ST_ADDR: byte_d = data_d[15:8];
            default: byte_d = data_d[7:0];
        endcase
        bit_val_d = byte_d[3'd7 - bit_d];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            data_q    <= 16'd0;
            ack_err_q <= 1'b0;
            end_q     <= 1'b0;
            busy_q    <= 1'b0;
            pins_q    <= PINS_IDLE;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            end_q     <= (state_d == ST_DONE);
            busy_q    <= (state_d != ST_IDLE);
            pins_q    <= pins_for(state_d, qtr_d, bit_val_d);
        end
    end

    assign cfg_end   = end_q;
    assign busy      = busy_q;
    assign ack_err   = ack_err_q;
    assign sccb_scl  = pins_q.scl;
    assign sda_o     = pins_q.sda;
    assign sda_oe    = pins_q.oe;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ov7725_sccb_wr.sv
// Bench for ov7725_sccb_wr: drives writes, decodes the SCCB bus into bytes and
// START/STOP events, and compares against a bus-level expectation model.
module tb_ov7725_sccb_wr;

    localparam int Q       = 4;
    localparam int END_CYC = 116 * Q;

    logic        clk;
    logic        sys_rst;
    logic        cfg_start;
    logic [15:0] cfg_data;
    logic        cfg_end;
    logic        busy;
    logic        ack_err;
    logic        sccb_scl;
    logic        sda_o;
    logic        sda_oe;
    logic        sda_i;
    logic [3:0]  state_dbg;

    ov7725_sccb_wr #(.DEV_ID(8'h42), .QTR_DIV(Q)) dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_end   (cfg_end),
        .busy      (busy),
        .ack_err   (ack_err),
        .sccb_scl  (sccb_scl),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         end_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_starts = 0;
    int         exp_stops = 0;
    int         seen_starts = 0;
    int         seen_stops = 0;
    logic       exp_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic       p_scl = 1'b1;
    logic       p_line = 1'b1;
    int         bitcnt = 0;
    logic [7:0] sh = 8'd0;

    always @(negedge clk) begin
        logic line;
        line = sda_oe ? sda_o : 1'b1;
        if (p_scl && sccb_scl && p_line && !line) begin
            seen_starts++;
            bitcnt = 0;
        end else if (p_scl && sccb_scl && !p_line && line) begin
            seen_stops++;
            bitcnt = 0;
        end else if (!p_scl && sccb_scl) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], line};
                bitcnt++;
            end else begin
                chk("ack_release", sda_oe, 1'b0);
                if (exp_q.size() > 0) chk("byte", sh, exp_q.pop_front());
                else chk("byte_extra", exp_q.size(), 1);
                bitcnt = 0;
            end
        end
        if (cfg_end) begin
            if (end_q.size() > 0) chk("end_cycle", cyc, end_q.pop_front());
            else chk("end_unexpected", cfg_end, 1'b0);
        end
        p_scl  = sccb_scl;
        p_line = line;
    end

    // ---------------- driver ----------------
    // mode 0: plain write, 1: extra cfg_start mid-write, 2: NACK in ACK2 slot,
    // 3: reset during DATA bit 3
    task automatic run_write(input logic [15:0] data, input int mode);
        int  t0;
        int  n;
        bit  done;
        @(negedge clk);
        chk("idle_scl", sccb_scl, 1'b1);
        chk("idle_oe", sda_oe, 1'b0);
        chk("idle_sda", sda_o, 1'b1);
        chk("idle_busy", busy, 1'b0);
        cfg_start = 1'b1;
        cfg_data  = data;
        t0 = cyc;
        exp_q.push_back(8'h42);
        exp_q.push_back(data[15:8]);
        exp_starts++;
        if (mode != 3) begin
            exp_q.push_back(data[7:0]);
            end_q.push_back(t0 + END_CYC);
            exp_stops++;
        end
        done = 1'b0;
        for (int k = 1; k <= END_CYC + 8 && !done; k++) begin
            @(negedge clk);
            n = cyc - t0;
            cfg_start = 1'b0;
            cfg_data  = 16'($urandom);
            if (n == 1) chk("busy_rise", busy, 1'b1);
            if (mode == 1 && n == 100) begin
                chk("busy_mid", busy, 1'b1);
                cfg_start = 1'b1;
                cfg_data  = 16'hffff;
            end
            if (mode == 2) begin
                if (n == 72 * Q) sda_i = 1'b1;
                if (n == 76 * Q) sda_i = 1'b0;
                if (n == 75 * Q - 1) chk("ack_err_before", ack_err, 1'b0);
                if (n == 75 * Q) begin
                    exp_ack = 1'b1;
                    chk("ack_err_rise", ack_err, 1'b1);
                end
            end
            if (mode == 3) begin
                if (n == 88 * Q + 1) sys_rst = 1'b1;
                if (n == 88 * Q + 2) begin
                    chk("rst_scl", sccb_scl, 1'b1);
                    chk("rst_oe", sda_oe, 1'b0);
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_end", cfg_end, 1'b0);
                    sys_rst = 1'b0;
                    exp_ack = 1'b0;
                end
            end
            if (cfg_end) begin
                chk("busy_at_end", busy, 1'b1);
                chk("ack_err", ack_err, exp_ack);
                done = 1'b1;
            end
        end
        if (mode != 3 && !done) chk("end_timeout", done, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sys_rst   = 1'b1;
        cfg_start = 1'b0;
        cfg_data  = 16'h0;
        sda_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_scl", sccb_scl, 1'b1);
        chk("reset_sda", sda_o, 1'b1);
        chk("reset_oe", sda_oe, 1'b0);
        chk("reset_end", cfg_end, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ack_err", ack_err, 1'b0);
        chk("reset_state", state_dbg, 4'd0);
        sys_rst = 1'b0;

        run_write(16'h1280, 0);
        run_write(16'h3d03, 0);
        run_write(16'h1500, 0);
        run_write(16'ha55a, 1);

        run_write(16'h0c10, 2);
        repeat (5) @(negedge clk);
        chk("ack_err_sticky", ack_err, 1'b1);
        sys_rst = 1'b1;
        @(negedge clk);
        chk("ack_err_cleared", ack_err, 1'b0);
        exp_ack = 1'b0;
        sys_rst = 1'b0;

        run_write(16'h6e22, 3);
        run_write(16'h1100, 0);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_write(16'($urandom), 0);
        end

        repeat (10) @(negedge clk);
        chk("bytes_left", exp_q.size(), 0);
        chk("ends_left", end_q.size(), 0);
        chk("start_count", seen_starts, exp_starts);
        chk("stop_count", seen_stops, exp_stops);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
